// File: rtl/fsm_umbrales_param.sv
// Flow-control FSM for the QoS FIFO array: validates per-FIFO high/low thresholds,
// drives hysteretic per-FIFO pause and keeps a sticky record of overflows.
module fsm_umbrales_param #(
    parameter int NUM_FIFOS = 5,
    parameter int CNT_W     = 5
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic [NUM_FIFOS*CNT_W-1:0] umbral_high_in,
    input  logic [NUM_FIFOS*CNT_W-1:0] umbral_low_in,
    input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
    input  logic [NUM_FIFOS-1:0]       fifo_ovf,
    output logic                       init_out,
    output logic                       idle_out,
    output logic                       active_out,
    output logic                       error_out,
    output logic [NUM_FIFOS-1:0]       error_full,
    output logic                       cfg_error,
    output logic [NUM_FIFOS-1:0]       pause
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } stateT;

    stateT                      r_state;
    stateT                      w_stateNext;
    logic [NUM_FIFOS*CNT_W-1:0] r_high;
    logic [NUM_FIFOS*CNT_W-1:0] r_low;
    logic [NUM_FIFOS-1:0]       r_errorFull;
    logic [NUM_FIFOS-1:0]       w_errorFullNext;
    logic                       r_cfgError;
    logic                       w_cfgErrorNext;
    logic [NUM_FIFOS-1:0]       r_pause;
    logic [NUM_FIFOS-1:0]       w_pauseNext;
    logic [NUM_FIFOS-1:0]       w_hystPause;
    logic                       w_cfgBad;
    logic                       w_anyOvf;
    logic                       w_anyCount;
    logic [CNT_W-1:0]           w_hi;
    logic [CNT_W-1:0]           w_lo;
    logic [CNT_W-1:0]           w_cnt;

    // While in INIT the thresholds being latched this edge are the ones that take effect.
    always_comb begin
        w_cfgBad    = 1'b0;
        w_hystPause = r_pause;
        w_hi        = '0;
        w_lo        = '0;
        w_cnt       = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (umbral_low_in[i*CNT_W +: CNT_W] >= umbral_high_in[i*CNT_W +: CNT_W])
                w_cfgBad = 1'b1;
            w_hi  = (r_state == S_INIT) ? umbral_high_in[i*CNT_W +: CNT_W] : r_high[i*CNT_W +: CNT_W];
            w_lo  = (r_state == S_INIT) ? umbral_low_in[i*CNT_W +: CNT_W]  : r_low[i*CNT_W +: CNT_W];
            w_cnt = fifo_count[i*CNT_W +: CNT_W];
            if (w_cnt >= w_hi)
                w_hystPause[i] = 1'b1;
            else if (w_cnt <= w_lo)
                w_hystPause[i] = 1'b0;
        end
    end

    assign w_anyOvf   = |fifo_ovf;
    assign w_anyCount = |fifo_count;

    always_comb begin
        w_stateNext     = r_state;
        w_errorFullNext = r_errorFull;
        w_cfgErrorNext  = r_cfgError;
        w_pauseNext     = '0;
        case (r_state)
            S_RESET: w_stateNext = S_INIT;
            S_INIT: begin
                if (!init && w_cfgBad)
                    w_cfgErrorNext = 1'b1;
                if (w_anyOvf) begin
                    w_stateNext     = S_ERROR;
                    w_errorFullNext = fifo_ovf;
                end else if (!init) begin
                    w_stateNext = w_cfgBad ? S_ERROR : S_IDLE;
                end
            end
            S_IDLE, S_ACTIVE: begin
                if (w_anyOvf) begin
                    w_stateNext     = S_ERROR;
                    w_errorFullNext = fifo_ovf;
                end else if (init) begin
                    w_stateNext = S_INIT;
                end else begin
                    w_stateNext = w_anyCount ? S_ACTIVE : S_IDLE;
                end
            end
            S_ERROR: w_errorFullNext = r_errorFull | fifo_ovf;
            default: w_stateNext = S_RESET;
        endcase
        // Pause follows the state being entered so it lines up with the state flags.
        case (w_stateNext)
            S_ERROR:          w_pauseNext = '1;
            S_IDLE, S_ACTIVE: w_pauseNext = w_hystPause;
            default:          w_pauseNext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_RESET;
            r_high      <= '0;
            r_low       <= '0;
            r_errorFull <= '0;
            r_cfgError  <= 1'b0;
            r_pause     <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_errorFull <= w_errorFullNext;
            r_cfgError  <= w_cfgErrorNext;
            r_pause     <= w_pauseNext;
            if (r_state == S_INIT) begin
                r_high <= umbral_high_in;
                r_low  <= umbral_low_in;
            end
        end
    end

    assign init_out   = (r_state == S_INIT);
    assign idle_out   = (r_state == S_IDLE);
    assign active_out = (r_state == S_ACTIVE);
    assign error_out  = (r_state == S_ERROR);
    assign error_full = r_errorFull;
    assign cfg_error  = r_cfgError;
    assign pause      = r_pause;

endmodule

// File: tb/tb_fsm_umbrales_param.sv
// Scoreboard bench for fsm_umbrales_param: each driven cycle queues the expected
// outputs, which are popped and compared one edge later.
module tb_fsm_umbrales_param;

    localparam int N = 5;
    localparam int W = 5;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INIT = 4'b1000;
    localparam logic [3:0] F_IDLE = 4'b0100;
    localparam logic [3:0] F_ACT  = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0001;

    logic             clock = 1'b0;
    logic             resetL = 1'b0;
    logic             initIn = 1'b0;
    logic [N*W-1:0]   highIn;
    logic [N*W-1:0]   lowIn;
    logic [N*W-1:0]   countIn = '0;
    logic [N-1:0]     ovfIn = '0;
    logic             initOut, idleOut, activeOut, errorOut, cfgError;
    logic [N-1:0]     errorFull, pauseOut;

    typedef struct packed {
        logic [3:0]   flags;
        logic [N-1:0] ef;
        logic         cfg;
        logic [N-1:0] pause;
    } expT;

    expT expQ[$];
    int  numChecks = 0;
    int  numErrors = 0;

    fsm_umbrales_param #(.NUM_FIFOS(N), .CNT_W(W)) dut (
        .clk           (clock),
        .reset_L       (resetL),
        .init          (initIn),
        .umbral_high_in(highIn),
        .umbral_low_in (lowIn),
        .fifo_count    (countIn),
        .fifo_ovf      (ovfIn),
        .init_out      (initOut),
        .idle_out      (idleOut),
        .active_out    (activeOut),
        .error_out     (errorOut),
        .error_full    (errorFull),
        .cfg_error     (cfgError),
        .pause         (pauseOut)
    );

    always #5 clock = ~clock;

    function automatic logic [N*W-1:0] cntOne(input int idx, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[idx*W +: W] = v;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [3:0] fl, input logic [N-1:0] ef, input logic cfg, input logic [N-1:0] pa);
        expT e;
        e.flags = fl;
        e.ef    = ef;
        e.cfg   = cfg;
        e.pause = pa;
        expQ.push_back(e);
    endtask

    task automatic compareNext(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, "_flags"}, 32'({initOut, idleOut, activeOut, errorOut}), 32'(e.flags));
        checkOutput({tag, "_errFull"}, 32'(errorFull), 32'(e.ef));
        checkOutput({tag, "_cfgErr"}, 32'(cfgError), 32'(e.cfg));
        checkOutput({tag, "_pause"}, 32'(pauseOut), 32'(e.pause));
    endtask

    task automatic applyStimulus(input string tag, input logic iv, input logic [N*W-1:0] cnt,
                                 input logic [N-1:0] ovf, input logic [3:0] fl,
                                 input logic [N-1:0] ef, input logic cfg, input logic [N-1:0] pa);
        @(negedge clock);
        initIn  = iv;
        countIn = cnt;
        ovfIn   = ovf;
        pushExp(fl, ef, cfg, pa);
        @(posedge clock);
        #1;
        compareNext(tag);
    endtask

    // Reset asserted between edges must clear outputs immediately; one edge after release the FSM is in INIT.
    task automatic asyncReset(input string tag);
        @(negedge clock);
        initIn  = 1'b0;
        countIn = '0;
        ovfIn   = '0;
        #2 resetL = 1'b0;
        pushExp(F_NONE, '0, 1'b0, '0);
        #1 compareNext({tag, "_async"});
        @(negedge clock);
        resetL = 1'b1;
        pushExp(F_INIT, '0, 1'b0, '0);
        @(posedge clock);
        #1 compareNext({tag, "_release"});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        highIn = {N{5'd14}};
        lowIn  = {N{5'd2}};

        // Power-on reset and initialisation
        repeat (2) @(posedge clock);
        #1;
        pushExp(F_NONE, '0, 1'b0, '0);
        compareNext("porReset");
        @(negedge clock);
        resetL = 1'b1;
        pushExp(F_INIT, '0, 1'b0, '0);
        @(posedge clock);
        #1 compareNext("porRelease");
        applyStimulus("init1", 1'b1, '0, '0, F_INIT, '0, 1'b0, '0);
        applyStimulus("init2", 1'b1, '0, '0, F_INIT, '0, 1'b0, '0);
        applyStimulus("toIdle", 1'b0, '0, '0, F_IDLE, '0, 1'b0, '0);
        applyStimulus("idleHold", 1'b0, '0, '0, F_IDLE, '0, 1'b0, '0);

        // Hysteresis on FIFO 3 with high=14, low=2
        for (int v = 1; v <= 15; v++)
            applyStimulus($sformatf("up%0d", v), 1'b0, cntOne(3, W'(v)), '0, F_ACT, '0, 1'b0,
                          (v >= 14) ? 5'b01000 : 5'b00000);
        for (int v = 14; v >= 0; v--)
            applyStimulus($sformatf("down%0d", v), 1'b0, cntOne(3, W'(v)), '0,
                          (v == 0) ? F_IDLE : F_ACT, '0, 1'b0,
                          (v >= 3) ? 5'b01000 : 5'b00000);

        // Overflow beats init in IDLE
        applyStimulus("prio", 1'b1, '0, 5'b00001, F_ERR, 5'b00001, 1'b0, 5'b11111);
        applyStimulus("prioHold", 1'b1, '0, '0, F_ERR, 5'b00001, 1'b0, 5'b11111);

        // Mid-operation reset while ACTIVE with pause[0] set
        asyncReset("rst1");
        applyStimulus("rst1Idle", 1'b0, '0, '0, F_IDLE, '0, 1'b0, '0);
        applyStimulus("rst1Act", 1'b0, cntOne(0, 5'd15), '0, F_ACT, '0, 1'b0, 5'b00001);
        asyncReset("rst2");

        // Invalid threshold pair on FIFO 1
        highIn[1*W +: W] = 5'd3;
        lowIn[1*W +: W]  = 5'd3;
        applyStimulus("badInit", 1'b1, '0, '0, F_INIT, '0, 1'b0, '0);
        applyStimulus("badExit", 1'b0, '0, '0, F_ERR, '0, 1'b1, 5'b11111);
        applyStimulus("badSticky", 1'b1, '0, '0, F_ERR, '0, 1'b1, 5'b11111);
        highIn = {N{5'd14}};
        lowIn  = {N{5'd2}};

        // Overflow in ACTIVE, then accumulation while in ERROR
        asyncReset("rst3");
        applyStimulus("ovfIdle", 1'b0, '0, '0, F_IDLE, '0, 1'b0, '0);
        applyStimulus("ovfAct", 1'b0, cntOne(0, 5'd5), '0, F_ACT, '0, 1'b0, '0);
        applyStimulus("ovf4", 1'b0, cntOne(0, 5'd5), 5'b10000, F_ERR, 5'b10000, 1'b0, 5'b11111);
        applyStimulus("ovfQuiet", 1'b0, cntOne(0, 5'd5), '0, F_ERR, 5'b10000, 1'b0, 5'b11111);
        applyStimulus("ovf1", 1'b0, '0, 5'b00010, F_ERR, 5'b10010, 1'b0, 5'b11111);
        applyStimulus("ovfInit", 1'b1, '0, '0, F_ERR, 5'b10010, 1'b0, 5'b11111);

        // Overflow on the edge INIT would exit with valid thresholds
        asyncReset("rst4");
        applyStimulus("exitInit", 1'b1, '0, '0, F_INIT, '0, 1'b0, '0);
        applyStimulus("exitOvf", 1'b0, '0, 5'b00100, F_ERR, 5'b00100, 1'b0, 5'b11111);

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
